interrupt_ctl: RTL and testbench
================================

# interrupt_ctl

Interrupt controller for the SM83 core: owns the IF (FF0F) and IE (FFFF) registers, edge-detects the peripheral and joypad request lines, and drives the pending-interrupt vector `CPU_IRQ_TRIG` into the CPU bottom block. It consumes the bottom block's one-hot `CPU_IRQ_ACK` to retire serviced requests. It also produces the HALT/STOP wake signal and the dispatch vector.

## Interface
Parameters: none. Addresses and bit indices are package constants.
- CLK  in  1  single system clock; all state changes on its rising edge
- nRES  in  1  asynchronous, active-low reset
- A  in  16  CPU address bus
- D_in  in  8  CPU write data
- D_out  out  8  read data; 0xFF when not selected
- RD  in  1  one-cycle read strobe
- WR  in  1  one-cycle write strobe
- SEL  out  1  combinational; high when A = FF0F or FFFF, used by the bus mux
- INT_SRC  in  4  level requests, active-high, already synchronous: [0] VBlank, [1] STAT, [2] Timer, [3] Serial
- JOYP_n  in  4  asynchronous active-low button lines
- CPU_IRQ_TRIG  out  8  [4:0] = IF & IE[4:0], [7:5] = 0
- CPU_IRQ_ACK  in  8  one-hot clear from the CPU; bits [7:5] ignored
- WAKE  out  1  OR of CPU_IRQ_TRIG, independent of IME
- VEC  out  8  0x40 + 8·k, where k is the lowest set bit of CPU_IRQ_TRIG; 0x00 if none

## Operation
- Request edges:
  - INT_SRC[i]: rising edge = INT_SRC[i] & ~src_q[i]; src_q is registered every cycle.
  - Joypad: each JOYP_n bit passes a 2-flop synchronizer. Any synchronized falling edge (sync_q & ~sync) on any line is request bit 4.
- IF next-state, per bit: `IF' = ((WR & A==FF0F) ? D_in[4:0] : IF) & ~ACK[4:0] | set[4:0]`.
  - Precedence: source set > ACK clear > CPU write.
- IE:
  - Full 8-bit register, written when WR & A==FFFF.
  - All 8 bits are readable; only [4:0] gate TRIG.
- Reads:
  - RD & A==FF0F gives {3'b111, IF}.
  - RD & A==FFFF gives IE.
  - Otherwise 0xFF.
- Priority: bit 0 is highest and bit 4 is lowest; VEC is 0x40, 0x48, 0x50, 0x58, 0x60.
- ACK of a bit that is not pending has no effect. A multi-hot ACK clears every named bit.

## Timing
- Reset state:
  - IF = 0, IE = 0.
  - src_q = 4'hF and joypad sync flops = 1, so lines already active at reset release do not raise spurious edges.
  - Outputs: CPU_IRQ_TRIG = 0, WAKE = 0, VEC = 0, D_out = 0xFF. SEL follows A.
- Latency:
  - INT_SRC rising edge sampled at clock n sets IF at edge n; TRIG, WAKE and VEC are valid combinationally after edge n.
  - JOYP_n fall sets IF[4] at the 3rd rising edge after the pin falls: 2 sync edges, then the edge-detect edge.
  - IF/IE write is visible in TRIG from the next cycle.
  - ACK at edge n clears the bit at edge n, unless the same bit is set at edge n.
- Reads are combinational, same cycle as RD.
- A source held high sets IF only once. A new edge requires the source to go low for at least 1 cycle.
- nRES asserted mid-operation returns everything to the reset state immediately; pending requests are lost.

## Structure
- Package `dmg_irq_pkg`:
  - IF_ADDR = 16'hFF0F, IE_ADDR = 16'hFFFF
  - Bit indices IRQ_VBLANK = 0, IRQ_STAT = 1, IRQ_TIMER = 2, IRQ_SERIAL = 3, IRQ_JOYPAD = 4
  - VEC_BASE = 8'h40, VEC_STRIDE = 8
- Sub-module `irq_sync_edge`: parameterised width, configurable polarity and synchronizer depth (0 or 2), reset value 1. Instantiated once for INT_SRC (depth 0, rising) and once for JOYP_n (depth 2, falling).

## Test plan
- Reset, then IE = 0x1F; pulse INT_SRC[2] for 1 cycle → TRIG = 0x04, VEC = 0x50, WAKE = 1. ACK = 0x04 → TRIG = 0x00 next cycle.
- IF = 0x1F by write and IE = 0x05 → TRIG = 0x05, VEC = 0x40. ACK 0x01 → VEC = 0x50. Read FF0F → 0xFE.
- Same cycle: INT_SRC[0] rises, ACK = 0x01 and IF write of 0x00 → IF[0] = 1 afterwards (set wins).
- Drop JOYP_n[1] to 0 asynchronously with IE = 0x10 → IF[4] set exactly 3 clocks later. Holding low causes no re-trigger; release and re-press triggers again.
- INT_SRC = 4'hF held through reset release → IF stays 0. Assert nRES mid-pending → TRIG = 0 and D_out = 0xFF at once.
- Read of a non-decoded address (FF10) → SEL = 0, D_out = 0xFF. Writing IE = 0xE0 → TRIG stays 0 while IF = 0x1F; readback of IE = 0xE0.

Source files
------------

// File: rtl/dmg_irq_pkg.sv
// Package for the SM83 interrupt controller: register addresses, request
// bit indices, dispatch vector constants and the priority-vector helper.
package dmg_irq_pkg;

  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;

  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_STAT   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;
  localparam int unsigned IRQ_COUNT  = 5;

  localparam logic [7:0] VEC_BASE   = 8'h40;
  localparam logic [7:0] VEC_STRIDE = 8'd8;

  // Dispatch address of the highest-priority (lowest-index) pending bit;
  // 0x00 when nothing is pending.
  function automatic logic [7:0] irq_vector(input logic [IRQ_COUNT-1:0] pend);
    logic [7:0] v;
    logic       found;
    v     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
      if (pend[i] && !found) begin
        v     = VEC_BASE + VEC_STRIDE * 8'(i);
        found = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/interrupt_ctl_if.sv
// CPU register bus for the interrupt controller.
//   A      : address          D_in : write data     D_out : read data
//   RD/WR  : one-cycle strobes SEL : address decode hit (FF0F / FFFF)
interface interrupt_ctl_if;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic [7:0]  D_out;
  logic        RD;
  logic        WR;
  logic        SEL;

  modport master (output A, D_in, RD, WR, input D_out, SEL);
  modport slave  (input A, D_in, RD, WR, output D_out, SEL);
endinterface

// File: rtl/irq_sync_edge.sv
// Optional 2-flop synchronizer followed by a single-cycle edge detector.
//   clk, rst_n : clock, async active-low reset (all flops reset to 1)
//   din        : request lines (WIDTH bits)
//   pulse      : one-cycle pulse per detected edge
// RISING selects rising (1) or falling (0) edges; DEPTH 2 adds the
// synchronizer, any other depth samples din directly.
module irq_sync_edge #(
  parameter int unsigned WIDTH  = 1,
  parameter bit          RISING = 1'b1,
  parameter int unsigned DEPTH  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] sampled;
  logic [WIDTH-1:0] prev_q;

  generate
    if (DEPTH == 2) begin : g_sync
      logic [WIDTH-1:0] s1_q;
      logic [WIDTH-1:0] s2_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_q <= '1;
          s2_q <= '1;
        end else begin
          s1_q <= din;
          s2_q <= s1_q;
        end
      end
      assign sampled = s2_q;
    end else begin : g_direct
      assign sampled = din;
    end
  endgenerate

  // Reset to all-ones so lines already high/active at release are not edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '1;
    else        prev_q <= sampled;
  end

  assign pulse = RISING ? (sampled & ~prev_q) : (prev_q & ~sampled);

endmodule

// File: rtl/interrupt_ctl.sv
// SM83 interrupt controller: IF (FF0F) / IE (FFFF) registers, request edge
// detection, pending vector to the CPU, HALT/STOP wake and dispatch vector.
//   CLK, nRES    : clock, async active-low reset
//   bus          : CPU register bus (slave side)
//   INT_SRC      : level requests VBlank/STAT/Timer/Serial, synchronous
//   JOYP_n       : asynchronous active-low joypad lines
//   CPU_IRQ_TRIG : IF & IE[4:0], upper bits zero
//   CPU_IRQ_ACK  : one-hot (or multi-hot) clear of serviced bits
//   WAKE         : any request pending and enabled
//   VEC          : dispatch address of the highest-priority pending bit
module interrupt_ctl
  import dmg_irq_pkg::*;
(
  input  logic                 CLK,
  input  logic                 nRES,
  interrupt_ctl_if.slave       bus,
  input  logic [3:0]           INT_SRC,
  input  logic [3:0]           JOYP_n,
  output logic [7:0]           CPU_IRQ_TRIG,
  input  logic [7:0]           CPU_IRQ_ACK,
  output logic                 WAKE,
  output logic [7:0]           VEC
);

  logic [IRQ_COUNT-1:0] if_q;
  logic [IRQ_COUNT-1:0] if_next;
  logic [7:0]           ie_q;
  logic [IRQ_COUNT-1:0] irq_set;
  logic [3:0]           src_edge;
  logic [3:0]           joy_edge;
  logic                 hit_if;
  logic                 hit_ie;
  logic [IRQ_COUNT-1:0] pend;
  logic                 unused_ack_hi;

  assign unused_ack_hi = &{1'b0, CPU_IRQ_ACK[7:5]};

  irq_sync_edge #(.WIDTH(4), .RISING(1'b1), .DEPTH(0)) u_src_edge (
    .clk   (CLK),
    .rst_n (nRES),
    .din   (INT_SRC),
    .pulse (src_edge)
  );

  irq_sync_edge #(.WIDTH(4), .RISING(1'b0), .DEPTH(2)) u_joy_edge (
    .clk   (CLK),
    .rst_n (nRES),
    .din   (JOYP_n),
    .pulse (joy_edge)
  );

  assign hit_if  = (bus.A == IF_ADDR);
  assign hit_ie  = (bus.A == IE_ADDR);
  assign bus.SEL = hit_if | hit_ie;

  always_comb begin
    irq_set             = '0;
    irq_set[IRQ_VBLANK] = src_edge[IRQ_VBLANK];
    irq_set[IRQ_STAT]   = src_edge[IRQ_STAT];
    irq_set[IRQ_TIMER]  = src_edge[IRQ_TIMER];
    irq_set[IRQ_SERIAL] = src_edge[IRQ_SERIAL];
    irq_set[IRQ_JOYPAD] = |joy_edge;
  end

  // Source set beats ACK clear, which beats the CPU write.
  always_comb begin
    if_next = (((bus.WR && hit_if) ? bus.D_in[IRQ_COUNT-1:0] : if_q)
               & ~CPU_IRQ_ACK[IRQ_COUNT-1:0]) | irq_set;
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      if_q <= '0;
      ie_q <= '0;
    end else begin
      if_q <= if_next;
      if (bus.WR && hit_ie) ie_q <= bus.D_in;
    end
  end

  always_comb begin
    bus.D_out = '1;
    if (bus.RD && hit_if)      bus.D_out = {3'b111, if_q};
    else if (bus.RD && hit_ie) bus.D_out = ie_q;
  end

  assign pend         = if_q & ie_q[IRQ_COUNT-1:0];
  assign CPU_IRQ_TRIG = {3'b000, pend};
  assign WAKE         = |pend;
  assign VEC          = irq_vector(pend);

endmodule

// File: tb/tb_interrupt_ctl.sv
module tb_interrupt_ctl;

  logic       CLK;
  logic       nRES;
  logic [3:0] INT_SRC;
  logic [3:0] JOYP_n;
  logic [7:0] CPU_IRQ_TRIG;
  logic [7:0] CPU_IRQ_ACK;
  logic       WAKE;
  logic [7:0] VEC;

  int tests;
  int fails;

  interrupt_ctl_if bus ();

  interrupt_ctl dut (
    .CLK          (CLK),
    .nRES         (nRES),
    .bus          (bus),
    .INT_SRC      (INT_SRC),
    .JOYP_n       (JOYP_n),
    .CPU_IRQ_TRIG (CPU_IRQ_TRIG),
    .CPU_IRQ_ACK  (CPU_IRQ_ACK),
    .WAKE         (WAKE),
    .VEC          (VEC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    bus.A    = addr;
    bus.D_in = data;
    bus.WR   = 1'b1;
    tick();
    bus.WR   = 1'b0;
    bus.A    = 16'h0000;
  endtask

  task automatic read_check(input string name, input logic [15:0] addr,
                            input logic [7:0] exp);
    bus.A  = addr;
    bus.RD = 1'b1;
    #1;
    tests++;
    if (bus.D_out !== exp) begin
      fails++;
      $display("FAIL %s: D_out=%h expected %h", name, bus.D_out, exp);
    end
    bus.RD = 1'b0;
    bus.A  = 16'h0000;
  endtask

  task automatic test_reset();
    nRES = 1'b0; INT_SRC = 4'h0; JOYP_n = 4'hF; CPU_IRQ_ACK = 8'h00;
    bus.A = 16'h0000; bus.D_in = 8'h00; bus.RD = 1'b0; bus.WR = 1'b0;
    tick(); tick();
    tests++;
    if (CPU_IRQ_TRIG !== 8'h00 || WAKE !== 1'b0 || VEC !== 8'h00) begin
      fails++;
      $display("FAIL reset_out: trig=%h wake=%b vec=%h expected 00 0 00", CPU_IRQ_TRIG, WAKE, VEC);
    end
    tests++;
    if (bus.D_out !== 8'hFF) begin
      fails++;
      $display("FAIL reset_dout: D_out=%h expected ff", bus.D_out);
    end
    read_check("reset_if", 16'hFF0F, 8'hE0);
    read_check("reset_ie", 16'hFFFF, 8'h00);
    nRES = 1'b1;
    tick();
  endtask

  task automatic test_timer();
    bus_write(16'hFFFF, 8'h1F);
    INT_SRC = 4'h4;
    tick();
    INT_SRC = 4'h0;
    tests++;
    if (CPU_IRQ_TRIG !== 8'h04 || VEC !== 8'h50 || WAKE !== 1'b1) begin
      fails++;
      $display("FAIL timer_set: trig=%h vec=%h wake=%b expected 04 50 1", CPU_IRQ_TRIG, VEC, WAKE);
    end
    CPU_IRQ_ACK = 8'h04;
    tick();
    CPU_IRQ_ACK = 8'h00;
    tests++;
    if (CPU_IRQ_TRIG !== 8'h00 || VEC !== 8'h00 || WAKE !== 1'b0) begin
      fails++;
      $display("FAIL timer_ack: trig=%h vec=%h wake=%b expected 00 00 0", CPU_IRQ_TRIG, VEC, WAKE);
    end
  endtask

  task automatic test_priority();
    bus_write(16'hFF0F, 8'h1F);
    bus_write(16'hFFFF, 8'h05);
    tests++;
    if (CPU_IRQ_TRIG !== 8'h05 || VEC !== 8'h40) begin
      fails++;
      $display("FAIL prio_vblank: trig=%h vec=%h expected 05 40", CPU_IRQ_TRIG, VEC);
    end
    CPU_IRQ_ACK = 8'h01;
    tick();
    CPU_IRQ_ACK = 8'h00;
    tests++;
    if (CPU_IRQ_TRIG !== 8'h04 || VEC !== 8'h50) begin
      fails++;
      $display("FAIL prio_timer: trig=%h vec=%h expected 04 50", CPU_IRQ_TRIG, VEC);
    end
    read_check("prio_read_if", 16'hFF0F, 8'hFE);
  endtask

  task automatic test_set_wins();
    bus_write(16'hFF0F, 8'h00);
    INT_SRC     = 4'h1;
    CPU_IRQ_ACK = 8'h01;
    bus_write(16'hFF0F, 8'h00);
    INT_SRC     = 4'h0;
    CPU_IRQ_ACK = 8'h00;
    read_check("set_wins_if", 16'hFF0F, 8'hE1);
    tests++;
    if (CPU_IRQ_TRIG !== 8'h01) begin
      fails++;
      $display("FAIL set_wins_trig: trig=%h expected 01", CPU_IRQ_TRIG);
    end
    // ACK of a non-pending bit leaves IF alone.
    CPU_IRQ_ACK = 8'h02;
    tick();
    CPU_IRQ_ACK = 8'h00;
    read_check("ack_not_pending", 16'hFF0F, 8'hE1);
    // Multi-hot ACK clears each named bit.
    bus_write(16'hFF0F, 8'h07);
    CPU_IRQ_ACK = 8'h03;
    tick();
    CPU_IRQ_ACK = 8'h00;
    read_check("ack_multi_hot", 16'hFF0F, 8'hE4);
  endtask

  task automatic test_joypad();
    bus_write(16'hFF0F, 8'h00);
    bus_write(16'hFFFF, 8'h10);
    #3 JOYP_n = 4'b1101;
    for (int unsigned k = 1; k <= 3; k++) begin
      tick();
      tests++;
      if (CPU_IRQ_TRIG !== ((k == 3) ? 8'h10 : 8'h00)) begin
        fails++;
        $display("FAIL joy_latency_edge%0d: trig=%h expected %h", k, CPU_IRQ_TRIG,
                 (k == 3) ? 8'h10 : 8'h00);
      end
    end
    tests++;
    if (VEC !== 8'h60) begin
      fails++;
      $display("FAIL joy_vec: vec=%h expected 60", VEC);
    end
    CPU_IRQ_ACK = 8'h10;
    tick();
    CPU_IRQ_ACK = 8'h00;
    tick(); tick(); tick();
    tests++;
    if (CPU_IRQ_TRIG !== 8'h00) begin
      fails++;
      $display("FAIL joy_hold_no_retrig: trig=%h expected 00", CPU_IRQ_TRIG);
    end
    JOYP_n = 4'hF;
    tick(); tick(); tick(); tick();
    tests++;
    if (CPU_IRQ_TRIG !== 8'h00) begin
      fails++;
      $display("FAIL joy_release: trig=%h expected 00", CPU_IRQ_TRIG);
    end
    #3 JOYP_n = 4'b1101;
    tick(); tick();
    tests++;
    if (CPU_IRQ_TRIG !== 8'h00) begin
      fails++;
      $display("FAIL joy_repress_early: trig=%h expected 00", CPU_IRQ_TRIG);
    end
    tick();
    tests++;
    if (CPU_IRQ_TRIG !== 8'h10) begin
      fails++;
      $display("FAIL joy_repress: trig=%h expected 10", CPU_IRQ_TRIG);
    end
    JOYP_n = 4'hF;
  endtask

  task automatic test_reset_behaviour();
    nRES    = 1'b0;
    INT_SRC = 4'hF;
    tick();
    nRES = 1'b1;
    tick(); tick(); tick();
    read_check("held_src_no_edge", 16'hFF0F, 8'hE0);
    INT_SRC = 4'h0;
    bus_write(16'hFFFF, 8'h1F);
    INT_SRC = 4'h1;
    tick();
    tests++;
    if (CPU_IRQ_TRIG !== 8'h01) begin
      fails++;
      $display("FAIL pre_reset_pending: trig=%h expected 01", CPU_IRQ_TRIG);
    end
    #3 nRES = 1'b0;
    #1;
    tests++;
    if (CPU_IRQ_TRIG !== 8'h00 || WAKE !== 1'b0 || VEC !== 8'h00 || bus.D_out !== 8'hFF) begin
      fails++;
      $display("FAIL midrun_reset: trig=%h wake=%b vec=%h dout=%h expected 00 0 00 ff",
               CPU_IRQ_TRIG, WAKE, VEC, bus.D_out);
    end
    read_check("midrun_reset_ie", 16'hFFFF, 8'h00);
    @(posedge CLK);
    #1 nRES = 1'b1;
    INT_SRC = 4'h0;
    tick();
  endtask

  task automatic test_decode();
    bus.A  = 16'hFF10;
    bus.RD = 1'b1;
    #1;
    tests++;
    if (bus.SEL !== 1'b0 || bus.D_out !== 8'hFF) begin
      fails++;
      $display("FAIL decode_ff10: sel=%b dout=%h expected 0 ff", bus.SEL, bus.D_out);
    end
    bus.A = 16'hFF0F;
    #1;
    tests++;
    if (bus.SEL !== 1'b1) begin
      fails++;
      $display("FAIL decode_ff0f: sel=%b expected 1", bus.SEL);
    end
    bus.A = 16'hFFFF;
    #1;
    tests++;
    if (bus.SEL !== 1'b1) begin
      fails++;
      $display("FAIL decode_ffff: sel=%b expected 1", bus.SEL);
    end
    bus.RD = 1'b0;
    bus.A  = 16'h0000;
    bus_write(16'hFFFF, 8'hE0);
    bus_write(16'hFF0F, 8'h1F);
    tests++;
    if (CPU_IRQ_TRIG !== 8'h00 || WAKE !== 1'b0) begin
      fails++;
      $display("FAIL ie_upper_no_trig: trig=%h wake=%b expected 00 0", CPU_IRQ_TRIG, WAKE);
    end
    read_check("ie_readback", 16'hFFFF, 8'hE0);
    read_check("if_readback", 16'hFF0F, 8'hFF);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_timer();
    test_priority();
    test_set_wins();
    test_joypad();
    test_reset_behaviour();
    test_decode();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
